// File: rtl/axis_tmr_pkg.sv
// Shared types for the TMR AXI-Stream aligner: lane count, lane masks and aligner states.
package axis_tmr_pkg;

    localparam int N_LANES = 3;

    typedef logic [N_LANES-1:0] lane_mask_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        DEGRADED = 2'd2
    } align_state_t;

endpackage

// File: rtl/axis_tmr_fifo.sv
// Single-clock first-word-fall-through FIFO for one replica lane, with synchronous flush.
// ready is registered (!full after this cycle's push/pop) so it has no path from pop.
module axis_tmr_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ne,
    output logic             ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_nxt;
    logic [PW-1:0]    rd_nxt;
    logic             do_push;
    logic             do_pop;
    logic             full_nxt;

    assign do_push = push & ready;
    assign do_pop  = pop & ne;
    assign ne      = (wr_ptr != rd_ptr);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Extra pointer bit distinguishes full from empty when the index bits match.
    always_comb begin
        wr_nxt   = wr_ptr + PW'(do_push);
        rd_nxt   = rd_ptr + PW'(do_pop);
        full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ready  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ready  <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            ready  <= !full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/axis_tmr_aligner.sv
// Aligns three skewed replica AXI-Stream inputs into one wide triplet beat, with a watchdog
// that releases degraded beats. Optional skew statistics: define AXIS_TMR_ALIGNER_SKEW_STATS_EN.
module axis_tmr_aligner
    import axis_tmr_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [DATA_WIDTH-1:0]   S00_AXIS_TDATA,
    input  logic                    S00_AXIS_TLAST,
    input  logic                    S00_AXIS_TVALID,
    output logic                    S00_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0]   S01_AXIS_TDATA,
    input  logic                    S01_AXIS_TLAST,
    input  logic                    S01_AXIS_TVALID,
    output logic                    S01_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0]   S02_AXIS_TDATA,
    input  logic                    S02_AXIS_TLAST,
    input  logic                    S02_AXIS_TVALID,
    output logic                    S02_AXIS_TREADY,
    output logic [3*DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [2:0]              M_AXIS_TLAST,
    output logic [2:0]              M_AXIS_TUSER,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic [2:0]              err_timeout,
    input  logic                    err_clr,
`ifdef AXIS_TMR_ALIGNER_SKEW_STATS_EN
    output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] max_skew,
`endif
    output logic [1:0]              dbg_state
);

    // Handshake: a beat moves on a rising edge where TVALID and TREADY are both high.
    // M_AXIS_TVALID never depends on M_AXIS_TREADY; once high it holds with a stable
    // payload until accepted, except that err_clr deliberately drops the pending beat.

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    align_state_t        state;
    align_state_t        state_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    lane_mask_t          deg_mask;
    lane_mask_t          deg_mask_nxt;
    lane_mask_t          err;
    lane_mask_t          err_nxt;
    lane_mask_t          ne;
    lane_mask_t          s_valid;
    lane_mask_t          s_ready;
    lane_mask_t          out_mask;
    lane_mask_t          pop_mask;
    logic                out_valid;
    logic [DATA_WIDTH:0] s_data [N_LANES];
    logic [DATA_WIDTH:0] head   [N_LANES];

    assign s_data[0] = {S00_AXIS_TLAST, S00_AXIS_TDATA};
    assign s_data[1] = {S01_AXIS_TLAST, S01_AXIS_TDATA};
    assign s_data[2] = {S02_AXIS_TLAST, S02_AXIS_TDATA};
    assign s_valid   = {S02_AXIS_TVALID, S01_AXIS_TVALID, S00_AXIS_TVALID};

    assign S00_AXIS_TREADY = s_ready[0];
    assign S01_AXIS_TREADY = s_ready[1];
    assign S02_AXIS_TREADY = s_ready[2];

    for (genvar n = 0; n < N_LANES; n++) begin : g_lane
        axis_tmr_fifo #(
            .WIDTH (DATA_WIDTH + 1),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (ACLK),
            .rst_n (ARESETN),
            .flush (err_clr),
            .push  (s_valid[n]),
            .pop   (pop_mask[n]),
            .wdata (s_data[n]),
            .rdata (head[n]),
            .ne    (ne[n]),
            .ready (s_ready[n])
        );

        // Absent lanes read as zero so the voter never sees stale FIFO contents.
        assign M_AXIS_TDATA[n*DATA_WIDTH +: DATA_WIDTH] = out_mask[n] ? head[n][DATA_WIDTH-1:0] : '0;
        assign M_AXIS_TLAST[n] = out_mask[n] & head[n][DATA_WIDTH];
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        deg_mask_nxt = deg_mask;
        err_nxt      = err;
        out_valid    = 1'b0;
        out_mask     = '0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (&ne) begin
                    out_valid = 1'b1;
                    out_mask  = '1;
                end else if (|ne) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (&ne) begin
                    // IDLE keeps presenting the same triplet until it is accepted.
                    out_valid = 1'b1;
                    out_mask  = '1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    err_nxt      = err | ~ne;
                    deg_mask_nxt = ne;
                    state_nxt    = DEGRADED;
                    cnt_nxt      = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DEGRADED: begin
                out_valid = 1'b1;
                out_mask  = deg_mask;
                if (M_AXIS_TREADY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (err_clr) begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            deg_mask_nxt = '0;
            err_nxt      = '0;
        end
    end

    assign pop_mask = (out_valid && M_AXIS_TREADY) ? out_mask : '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= IDLE;
            cnt      <= '0;
            deg_mask <= '0;
            err      <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            deg_mask <= deg_mask_nxt;
            err      <= err_nxt;
        end
    end

    assign M_AXIS_TVALID = out_valid;
    assign M_AXIS_TUSER  = out_mask;
    assign err_timeout   = err;
    assign dbg_state     = state;

`ifdef AXIS_TMR_ALIGNER_SKEW_STATS_EN
    logic skew_evt;

    assign skew_evt = (state == WAIT) && ((&ne) || (cnt == TO_LAST));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            max_skew <= '0;
        end else if (err_clr) begin
            max_skew <= '0;
        end else if (skew_evt && (cnt > max_skew)) begin
            max_skew <= cnt;
        end
    end
`endif

endmodule

// File: tb/tb_axis_tmr_aligner.sv
// Directed scoreboard bench for axis_tmr_aligner: expected triplets are queued at stimulus
// time and a negedge monitor compares every accepted beat and checks stall stability.
module tb_axis_tmr_aligner;

    localparam int DW = 32;
    localparam int EW = 3*DW + 6;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_tdata  [3];
    logic [2:0]    s_tlast;
    logic [2:0]    s_tvalid;
    logic [2:0]    s_tready;
    logic [3*DW-1:0] M_AXIS_TDATA;
    logic [2:0]    M_AXIS_TLAST;
    logic [2:0]    M_AXIS_TUSER;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic [2:0]    err_timeout;
    logic          err_clr;
    logic [1:0]    dbg_state;
`ifdef AXIS_TMR_ALIGNER_SKEW_STATS_EN
    logic [8:0]    max_skew;
`endif

    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic          stab_en;
    logic          hold_valid;
    logic [EW-1:0] hold_val;
    logic [EW-1:0] obs;

    axis_tmr_aligner #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .ACLK            (clk),
        .ARESETN         (rst_n),
        .S00_AXIS_TDATA  (s_tdata[0]),
        .S00_AXIS_TLAST  (s_tlast[0]),
        .S00_AXIS_TVALID (s_tvalid[0]),
        .S00_AXIS_TREADY (s_tready[0]),
        .S01_AXIS_TDATA  (s_tdata[1]),
        .S01_AXIS_TLAST  (s_tlast[1]),
        .S01_AXIS_TVALID (s_tvalid[1]),
        .S01_AXIS_TREADY (s_tready[1]),
        .S02_AXIS_TDATA  (s_tdata[2]),
        .S02_AXIS_TLAST  (s_tlast[2]),
        .S02_AXIS_TVALID (s_tvalid[2]),
        .S02_AXIS_TREADY (s_tready[2]),
        .M_AXIS_TDATA    (M_AXIS_TDATA),
        .M_AXIS_TLAST    (M_AXIS_TLAST),
        .M_AXIS_TUSER    (M_AXIS_TUSER),
        .M_AXIS_TVALID   (M_AXIS_TVALID),
        .M_AXIS_TREADY   (M_AXIS_TREADY),
        .err_timeout     (err_timeout),
        .err_clr         (err_clr),
`ifdef AXIS_TMR_ALIGNER_SKEW_STATS_EN
        .max_skew        (max_skew),
`endif
        .dbg_state       (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    assign obs = {M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [DW-1:0] d0, d1, d2,
                                         input logic [2:0] last, input logic [2:0] user);
        return {d2, d1, d0, last, user};
    endfunction

    function automatic logic [DW-1:0] bp_word(input int lane, input int beat);
        return {8'(lane + 1), 24'(beat)};
    endfunction

    // driver tasks
    task automatic push_beats(input logic [2:0] mask, input logic [DW-1:0] d0, d1, d2,
                              input logic [2:0] last);
        logic [2:0] pend;
        int         budget;
        pend       = mask;
        budget     = 0;
        s_tdata[0] = d0;
        s_tdata[1] = d1;
        s_tdata[2] = d2;
        s_tlast    = last;
        while (pend != 3'b000 && budget < 60) begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) s_tvalid[n] = pend[n] & s_tready[n];
            @(posedge clk);
            for (int n = 0; n < 3; n++) if (s_tvalid[n]) pend[n] = 1'b0;
            budget++;
        end
        @(negedge clk);
        s_tvalid = 3'b000;
        if (pend != 3'b000) check("push_timeout", 128'(pend), 128'(0));
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        #1;
        check("drain", 128'(exp_q.size()), 128'(0));
    endtask

    // scoreboard monitor
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid && stab_en) check("stall_stable", {M_AXIS_TVALID, obs}, {1'b1, hold_val});
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", obs);
                end else begin
                    check("beat", 128'(obs), 128'(exp_q.pop_front()));
                end
            end
            hold_valid = M_AXIS_TVALID && !M_AXIS_TREADY;
            hold_val   = obs;
        end
    end

    initial begin
        int k;
        rst_n         = 1'b0;
        s_tdata[0]    = '0;
        s_tdata[1]    = '0;
        s_tdata[2]    = '0;
        s_tlast       = 3'b000;
        s_tvalid      = 3'b000;
        M_AXIS_TREADY = 1'b0;
        err_clr       = 1'b0;
        stab_en       = 1'b1;
        hold_valid    = 1'b0;
        hold_val      = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid", 128'(M_AXIS_TVALID), 128'(0));
        check("rst_tuser", 128'(M_AXIS_TUSER), 128'(0));
        check("rst_tdata", 128'(M_AXIS_TDATA), 128'(0));
        check("rst_tlast", 128'(M_AXIS_TLAST), 128'(0));
        check("rst_err", 128'(err_timeout), 128'(0));
        check("rst_tready", 128'(s_tready), 128'(0));
        check("rst_state", 128'(dbg_state), 128'(0));
        @(negedge clk);
        rst_n         = 1'b1;
        M_AXIS_TREADY = 1'b1;

        // aligned triplet
        exp_q.push_back(mk(32'hA5A5_0001, 32'hA5A5_0001, 32'hA5A5_0001, 3'b000, 3'b111));
        push_beats(3'b111, 32'hA5A5_0001, 32'hA5A5_0001, 32'hA5A5_0001, 3'b000);
        #1;
        check("aligned_latency", 128'(M_AXIS_TVALID), 128'(1));
        check("aligned_err", 128'(err_timeout), 128'(0));
        wait_drain(20);

        // lane 2 skewed by 10 cycles, TLAST differs across lanes
        exp_q.push_back(mk(32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 3'b010, 3'b111));
        push_beats(3'b011, 32'hB000_0001, 32'hB000_0002, 32'h0, 3'b010);
        repeat (10) @(negedge clk);
        #1;
        check("skew_no_early", 128'(M_AXIS_TVALID), 128'(0));
        push_beats(3'b100, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 3'b010);
        wait_drain(20);
        check("skew_err", 128'(err_timeout), 128'(0));

        // lane 2 silent: degraded beat after the timeout
        exp_q.push_back(mk(32'h11, 32'h22, 32'h0, 3'b000, 3'b011));
        push_beats(3'b011, 32'h11, 32'h22, 32'h0, 3'b000);
        wait_drain(400);
        check("timeout_err", 128'(err_timeout), 128'(3'b100));
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("timeout_err_cleared", 128'(err_timeout), 128'(0));

        // backpressure: 9 beats into 8-deep FIFOs
        @(negedge clk);
        M_AXIS_TREADY = 1'b0;
        for (int b = 0; b < 9; b++)
            exp_q.push_back(mk(bp_word(0, b), bp_word(1, b), bp_word(2, b),
                               (b == 8) ? 3'b111 : 3'b000, 3'b111));
        for (int b = 0; b < 8; b++)
            push_beats(3'b111, bp_word(0, b), bp_word(1, b), bp_word(2, b), 3'b000);
        #1;
        check("bp_tready_low", 128'(s_tready), 128'(0));
        check("bp_tvalid_held", 128'(M_AXIS_TVALID), 128'(1));
        @(negedge clk);
        M_AXIS_TREADY = 1'b1;
        push_beats(3'b111, bp_word(0, 8), bp_word(1, 8), bp_word(2, 8), 3'b111);
        wait_drain(60);

        // err_clr while a degraded beat is stalled
        @(negedge clk);
        M_AXIS_TREADY = 1'b0;
        push_beats(3'b001, 32'h33, 32'h0, 32'h0, 3'b000);
        k = 0;
        while (!M_AXIS_TVALID && k < 300) begin
            @(negedge clk);
            k++;
        end
        #1;
        check("deg_valid", 128'(M_AXIS_TVALID), 128'(1));
        check("deg_user", 128'(M_AXIS_TUSER), 128'(3'b001));
        check("deg_data", 128'(M_AXIS_TDATA), 128'(32'h33));
        check("deg_err", 128'(err_timeout), 128'(3'b110));
        @(negedge clk);
        stab_en = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("clr_tvalid", 128'(M_AXIS_TVALID), 128'(0));
        check("clr_err", 128'(err_timeout), 128'(0));
        check("clr_tready", 128'(s_tready), 128'(3'b111));
        @(negedge clk);
        stab_en       = 1'b1;
        M_AXIS_TREADY = 1'b1;
        exp_q.push_back(mk(32'h44, 32'h45, 32'h46, 3'b000, 3'b111));
        push_beats(3'b111, 32'h44, 32'h45, 32'h46, 3'b000);
        wait_drain(20);

        // reset in the middle of WAIT
        push_beats(3'b001, 32'h55, 32'h0, 32'h0, 3'b000);
        repeat (101) @(negedge clk);
        #1;
        check("mid_wait_state", 128'(dbg_state), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", 128'(M_AXIS_TVALID), 128'(0));
        check("async_rst_tuser", 128'(M_AXIS_TUSER), 128'(0));
        check("async_rst_tdata", 128'(M_AXIS_TDATA), 128'(0));
        check("async_rst_tready", 128'(s_tready), 128'(0));
        check("async_rst_err", 128'(err_timeout), 128'(0));
        check("async_rst_state", 128'(dbg_state), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(32'h66, 32'h67, 32'h68, 3'b111, 3'b111));
        push_beats(3'b111, 32'h66, 32'h67, 32'h68, 3'b111);
        wait_drain(20);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_tmr_aligner.md
Name: axis_tmr_aligner

Overview:
- Upstream stage of the TMR AXI-Stream voter. It receives three replica streams (S00/S01/S02) that arrive with independent skew.
- Each replica is buffered in its own FIFO. The block releases beats as aligned triplets on one wide master port, which feeds the voter inputs.
- A watchdog detects a missing or late replica. On timeout it releases a degraded beat carrying a lane-present mask and latches a sticky per-lane error.

Parameters:
- DATA_WIDTH, 32, tdata width per replica.
- FIFO_DEPTH, 8, entries per replica FIFO. Must be a power of 2 and at least 2.
- TIMEOUT_CYCLES, 256, cycles allowed between the first and the last replica of a beat arriving. Must be at least 2.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous, active-low reset.
- S0n_AXIS_TDATA  in  DATA_WIDTH  replica n data (n = 0..2).
- S0n_AXIS_TLAST  in  1  replica n last.
- S0n_AXIS_TVALID  in  1  replica n valid.
- S0n_AXIS_TREADY  out  1  replica n ready.
- M_AXIS_TDATA  out  3*DATA_WIDTH  lane n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- M_AXIS_TLAST  out  3  per-lane last.
- M_AXIS_TUSER  out  3  lane-present mask.
- M_AXIS_TVALID  out  1  triplet valid.
- M_AXIS_TREADY  in  1  downstream ready.
- err_timeout  out  3  sticky; bit n set = lane n missing at a timeout.
- err_clr  in  1  single-cycle pulse; clears err_timeout and flushes all FIFOs.

Behaviour:
- Reset (asynchronous assert, synchronous deassert):
  - FIFO pointers are 0. State is IDLE. Counter is 0.
  - All TREADY = 0, M_AXIS_TVALID = 0, M_AXIS_TDATA/TLAST/TUSER = 0, err_timeout = 0.
  - A reset during a transfer drops all buffered beats.
- Input side:
  - S0n_AXIS_TREADY = !full_n. It is a registered-status signal and has no combinational path from M_AXIS_TREADY.
  - A push occurs on TVALID & TREADY. A full FIFO backpressures only its own lane.
- FIFO: full/empty use pointers that are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH. A push and pop in the same cycle on a full FIFO is disallowed, because TREADY=0 while full. The same on an empty FIFO cannot occur.
- The output is a combinational view of the FIFO heads, so latency from the last replica push to M_AXIS_TVALID is 1 cycle.
- ne[n] = FIFO n non-empty.
- State IDLE:
  - When all ne = 0, the counter is held at 0.
  - When all ne = 1, the block presents an aligned triplet: M_AXIS_TVALID = 1 and TUSER = 3'b111.
  - When some but not all ne are set, the next state is WAIT.
- State WAIT:
  - The counter increments each cycle.
  - If all ne become 1, the block presents the triplet and the next state is IDLE, with the counter cleared after the handshake.
  - If counter == TIMEOUT_CYCLES-1 while not all ne are set:
    - err_timeout |= ~ne.
    - The next state is DEGRADED.
- State DEGRADED:
  - M_AXIS_TVALID = 1 and TUSER = ne, sampled and frozen on entry.
  - Missing lanes drive TDATA = 0 and TLAST = 0.
  - On handshake, the block pops only the present lanes, then goes to IDLE with the counter at 0.
- Pop rules: pop on M_AXIS_TVALID & M_AXIS_TREADY. TVALID/TDATA stay stable while TREADY = 0 (AXIS rule). No beat is duplicated or lost.
- Simultaneous events:
  - A push into the missing lane on the timeout cycle: the lane is still flagged and is not included in the degraded beat.
  - err_clr has priority over everything: it flushes all FIFOs, clears the error, sets state IDLE and the counter to 0, and drops any in-flight output beat. M_AXIS_TVALID = 0 for the following cycle.
  - A push concurrent with err_clr is discarded.
- TLAST mismatch across lanes is passed through unaltered. The voter resolves it.

Optional Feature:
- Macro: AXIS_TMR_ALIGNER_SKEW_STATS_EN.
- Defined: adds output max_skew [$clog2(TIMEOUT_CYCLES+1)-1:0].
  - It is a running maximum of the WAIT-state counter value at alignment or timeout.
  - It is reset to 0 and cleared by err_clr.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package axis_tmr_pkg:
  - typedef enum {IDLE, WAIT, DEGRADED} align_state_t.
  - Constant N_LANES = 3.
  - Lane-mask typedef logic [N_LANES-1:0] lane_mask_t.
- Sub-module axis_tmr_fifo: single-clock, first-word-fall-through FIFO. It is instantiated 3 times and has a synchronous flush input.

Test Plan:
- Aligned: all lanes push 0xA5A5_0001 in the same cycle, with TREADY = 1 → one triplet, TUSER = 3'b111, TVALID high 1 cycle after the push, err_timeout = 0.
- Skew: lane 2 pushes 10 cycles after lanes 0/1, with TIMEOUT_CYCLES = 256 → one triplet with all three data words, no error.
- Timeout: lanes 0/1 push 0x11/0x22 and lane 2 is silent → after 256 cycles, TUSER = 3'b011, lane 2 TDATA = 0, err_timeout = 3'b100.
- Backpressure: 9 beats per lane, FIFO_DEPTH = 8, M_AXIS_TREADY = 0 → each S0n TREADY drops after the 8th beat. Releasing TREADY yields 9 ordered triplets with stable TDATA during stalls.
- err_clr during a degraded beat with TREADY = 0 → next cycle TVALID = 0, err_timeout = 0, all FIFOs empty, all TREADY = 1.
- Reset asserted mid-WAIT (counter = 100) → all outputs 0 immediately. After release, an aligned push produces a normal triplet.
